fir_sample_writer: RTL and testbench

Transmit side of the FIR sample-transfer handshake. Accepts input samples from upstream over a valid/ready interface, buffers them in a small FIFO and presents them one at a time to the FIR datapath using the Stop/Read request-acknowledge pair driven by the FIR `counter`. After each acknowledge it enforces a fixed hold window before the next transfer, giving the tap pipeline a settle period.

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_sample_fifo.sv | 65 ++++++
 rtl/fir_sample_writer.sv | 136 +++++++++++++
 tb/tb_fir_sample_writer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sample-transfer blocks.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } wr_state_t;

  localparam int FIR_DATA_W      = 16;
  localparam int FIR_HOLD_CYCLES = 3;

  // Bits needed for a counter that holds values 0 .. n-1 (never narrower than 1).
  function automatic int fir_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Small synchronous FIFO feeding fir_sample_writer. Push is ignored when full,
// pop is ignored when empty; the head entry is visible combinationally.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Push,
  input  logic                       Pop,
  input  logic signed [DATA_W-1:0]   WrData,
  output logic signed [DATA_W-1:0]   Head,
  output logic [$clog2(DEPTH+1)-1:0] Level,
  output logic                       Full,
  output logic                       Empty
);

  localparam int AW = fir_cnt_w(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic                     push_ok;
  logic                     pop_ok;

  // Occupancy update: +1 on push only, -1 on pop only, held otherwise; clamps at the ends.
  function automatic logic [LW-1:0] next_level(input logic [LW-1:0] lvl,
                                               input logic inc, input logic dec);
    if (inc && !dec)
      return (lvl == LW'(DEPTH)) ? lvl : lvl + LW'(1);
    else if (dec && !inc)
      return (lvl == '0) ? lvl : lvl - LW'(1);
    else
      return lvl;
  endfunction

  // Full is taken from the registered level, so a same-cycle pop never frees a slot for a push.
  assign Full    = (Level == LW'(DEPTH));
  assign Empty   = (Level == '0);
  assign push_ok = Push && !Full;
  assign pop_ok  = Pop && !Empty;
  assign Head    = mem[rd_ptr];

  // Sample storage; data only, so it carries no reset.
  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr] <= WrData;
  end

  // Pointers wrap naturally (DEPTH is a power of two) and level tracks occupancy.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      Level <= next_level(Level, push_ok, pop_ok);
    end
  end

endmodule

// File: rtl/fir_sample_writer.sv
// Transmit side of the FIR sample handshake: buffers upstream samples and hands
// them to the counter with a StopOut request / ReadIn acknowledge, then holds
// for HOLD_CYCLES before the next request.
// Optional feature: define FIR_WR_TIMEOUT_EN to abandon a request after TIMEOUT
// unacknowledged SEND cycles, set the sticky Error flag and retry the sample.
module fir_sample_writer
  import fir_pkg::*;
#(
  parameter int DATA_W      = FIR_DATA_W,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = FIR_HOLD_CYCLES,
  parameter int TIMEOUT     = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       InValid,
  input  logic signed [DATA_W-1:0]   InData,
  output logic                       InReady,
  output logic                       StopOut,
  output logic signed [DATA_W-1:0]   DataOut,
  input  logic                       ReadIn,
  output logic [$clog2(DEPTH+1)-1:0] Level,
  output logic                       Busy,
  output logic                       Error
);

  localparam int            HW        = fir_cnt_w(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  wr_state_t                state;
  logic [HW-1:0]            hold_cnt;
  logic signed [DATA_W-1:0] fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_pop;

`ifdef FIR_WR_TIMEOUT_EN
  localparam int            TW       = fir_cnt_w(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0]            tmo_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign Error          = 1'b0;
`endif

  // The sample leaves the FIFO on the same edge that sees the acknowledge.
  assign fifo_pop = (state == SEND) && ReadIn;
  assign InReady  = !fifo_full;

  fir_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .Clk    (Clk),
    .Reset  (Reset),
    .Push   (InValid),
    .Pop    (fifo_pop),
    .WrData (InData),
    .Head   (fifo_head),
    .Level  (Level),
    .Full   (fifo_full),
    .Empty  (fifo_empty)
  );

  // Request/acknowledge FSM with registered StopOut, DataOut, Busy and hold/timeout counters.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      StopOut  <= 1'b0;
      DataOut  <= '0;
      Busy     <= 1'b0;
      hold_cnt <= '0;
`ifdef FIR_WR_TIMEOUT_EN
      tmo_cnt  <= '0;
      Error    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            DataOut <= fifo_head;
            StopOut <= 1'b1;
            Busy    <= 1'b1;
            state   <= SEND;
`ifdef FIR_WR_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        SEND: begin
          if (ReadIn) begin
            StopOut  <= 1'b0;
            hold_cnt <= HOLD_INIT;
            state    <= HOLD;
          end
`ifdef FIR_WR_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            // Give up on this request without popping; the same head is retried after HOLD.
            Error    <= 1'b1;
            StopOut  <= 1'b0;
            hold_cnt <= HOLD_INIT;
            state    <= HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
          end else if (!ReadIn) begin
            // The counter must have released ReadIn before the next request goes out.
            if (!fifo_empty) begin
              DataOut <= fifo_head;
              StopOut <= 1'b1;
              state   <= SEND;
`ifdef FIR_WR_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              Busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          StopOut <= 1'b0;
          Busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_writer.sv
// Directed and randomized bench for fir_sample_writer against a queue-based model.
module tb_fir_sample_writer;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int HOLD  = 3;
  localparam int TMO   = 8;

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b0;
  logic                 InValid = 1'b0;
  logic signed [DW-1:0] InData = '0;
  logic                 ReadIn = 1'b0;
  logic                 InReady;
  logic                 StopOut;
  logic signed [DW-1:0] DataOut;
  logic [2:0]           Level;
  logic                 Busy;
  logic                 Error;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic auto_ack = 1'b0;

  logic signed [DW-1:0] q[$];
  int                   rise_cyc[$];
  logic signed [DW-1:0] rise_val[$];
  logic signed [DW-1:0] vals [4];

  always #5 Clk = ~Clk;

  fir_sample_writer #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD),
    .TIMEOUT     (TMO)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .InValid (InValid),
    .InData  (InData),
    .InReady (InReady),
    .StopOut (StopOut),
    .DataOut (DataOut),
    .ReadIn  (ReadIn),
    .Level   (Level),
    .Busy    (Busy),
    .Error   (Error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from what was presented at the edge, then compare.
  task automatic tick();
    logic p_stop, p_read, p_valid, p_full;
    logic signed [DW-1:0] p_data, p_dout;
    p_stop  = StopOut;
    p_read  = ReadIn;
    p_valid = InValid;
    p_data  = InData;
    p_dout  = DataOut;
    p_full  = (q.size() >= DEPTH);
    @(posedge Clk);
    #1;
    cyc++;
    if (!Reset) begin
      q.delete();
    end else begin
      if (p_stop && p_read) begin
        check("pop_nonempty", q.size() != 0, 1);
        if (q.size() != 0) void'(q.pop_front());
      end
      if (p_valid && !p_full) q.push_back(p_data);
    end
    if (auto_ack) ReadIn = p_stop;
    check("level", Level, q.size());
    check("inready", InReady, q.size() < DEPTH);
    if (StopOut) check("busy_in_send", Busy, 1);
    if (p_stop && p_read) check("stop_drop_after_ack", StopOut, 0);
    if (p_stop && StopOut) check("dout_stable", DataOut, p_dout);
    if (StopOut && !p_stop) begin
      check("stop_has_sample", q.size() != 0, 1);
      if (q.size() != 0) check("head_value", DataOut, q[0]);
      rise_cyc.push_back(cyc);
      rise_val.push_back(DataOut);
    end
`ifndef FIR_WR_TIMEOUT_EN
    check("error_tied_low", Error, 0);
`endif
  endtask

  task automatic wait_rise(input int budget, input string tag);
    int n;
    int rb;
    n  = 0;
    rb = rise_cyc.size();
    while (rise_cyc.size() == rb && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timely"}, rise_cyc.size() > rb, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vals[0] = -16'sd1;
    vals[1] = 16'sd2;
    vals[2] = -16'sd3;
    vals[3] = 16'sd4;

    // Reset held: all outputs at reset values, InReady high.
    repeat (3) tick();
    check("rst_stop", StopOut, 0);
    check("rst_dout", DataOut, 0);
    check("rst_level", Level, 0);
    check("rst_busy", Busy, 0);
    check("rst_error", Error, 0);
    check("rst_inready", InReady, 1);
    Reset = 1'b1;
    tick();
    tick();
    check("idle_no_stop", StopOut, 0);

    // Single max-positive sample with the counter attached.
    auto_ack = 1'b1;
    InValid = 1'b1;
    InData  = 16'sh7FFF;
    tick();
    InValid = 1'b0;
    check("t1_level_after_push", Level, 1);
    check("t1_no_stop_yet", StopOut, 0);
    tick();
    check("t1_stop_rise", StopOut, 1);
    check("t1_dout", DataOut, 16'sh7FFF);
    tick();
    check("t1_stop_2nd_cycle", StopOut, 1);
    tick();
    check("t1_level_after_ack", Level, 0);
    check("t1_hold_busy", Busy, 1);
    for (int i = 1; i < HOLD; i++) begin
      tick();
      check("t1_hold_busy", Busy, 1);
    end
    tick();
    check("t1_idle_busy", Busy, 0);
    check("t1_idle_stop", StopOut, 0);

    // Fill the FIFO, then a pop with a simultaneous rejected push.
    auto_ack = 1'b0;
    ReadIn   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      InValid = 1'b1;
      InData  = vals[i];
      tick();
    end
    InValid = 1'b0;
    check("t2_full_inready", InReady, 0);
    check("t2_full_level", Level, 4);
    check("t2_first_out", DataOut, vals[0]);
    rise_cyc.delete();
    rise_val.delete();
    InValid = 1'b1;
    InData  = 16'sd5;
    ReadIn  = 1'b1;
    tick();
    InValid = 1'b0;
    check("t3_full_push_rejected", Level, 3);
    auto_ack = 1'b1;
    repeat (20) tick();
    check("t2_rise_count", rise_val.size(), 3);
    for (int i = 0; i < 3 && i < rise_val.size(); i++)
      check("t2_order", rise_val[i], vals[i+1]);
    for (int i = 1; i < 3 && i < rise_cyc.size(); i++)
      check("t2_spacing", rise_cyc[i] - rise_cyc[i-1], 2 + HOLD);
    check("t2_end_level", Level, 0);
    check("t2_end_busy", Busy, 0);

    // Asynchronous reset in the middle of a transfer.
    auto_ack = 1'b0;
    ReadIn   = 1'b0;
    InValid  = 1'b1;
    InData   = 16'sd11;
    tick();
    InData   = 16'sd12;
    tick();
    InValid  = 1'b0;
    check("t4_pre_level", Level, 2);
    check("t4_pre_stop", StopOut, 1);
    #1;
    Reset = 1'b0;
    #1;
    q.delete();
    check("t4_rst_stop", StopOut, 0);
    check("t4_rst_dout", DataOut, 0);
    check("t4_rst_level", Level, 0);
    check("t4_rst_busy", Busy, 0);
    check("t4_rst_inready", InReady, 1);
    check("t4_rst_error", Error, 0);
    tick();
    Reset = 1'b1;
    repeat (6) tick();
    check("t4_no_stop", StopOut, 0);
    check("t4_level", Level, 0);
    check("t4_busy", Busy, 0);

    // ReadIn held high through HOLD blocks the next request.
    InValid = 1'b1;
    InData  = 16'sh1234;
    tick();
    InData  = 16'shFF00;
    tick();
    InValid = 1'b0;
    check("t5_stop", StopOut, 1);
    ReadIn = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_hold_stop", StopOut, 0);
      check("t5_hold_busy", Busy, 1);
    end
    ReadIn = 1'b0;
    tick();
    check("t5_advance_stop", StopOut, 1);
    check("t5_advance_dout", DataOut, 16'shFF00);
    ReadIn = 1'b1;
    tick();
    ReadIn = 1'b0;
    repeat (HOLD + 2) tick();
    check("t5_end_busy", Busy, 0);
    check("t5_end_level", Level, 0);

`ifndef FIR_WR_TIMEOUT_EN
    // Without the timeout option SEND waits indefinitely.
    InValid = 1'b1;
    InData  = -16'sd77;
    tick();
    InValid = 1'b0;
    repeat (TMO + 4) tick();
    check("nt_still_send", StopOut, 1);
    check("nt_level", Level, 1);
    ReadIn = 1'b1;
    tick();
    ReadIn = 1'b0;
    repeat (HOLD + 2) tick();
    check("nt_end_level", Level, 0);
`endif

    // Randomized traffic with random acknowledges.
    for (int i = 0; i < 400; i++) begin
      InValid = 1'($urandom_range(0, 1));
      InData  = DW'($urandom);
      ReadIn  = ($urandom_range(0, 2) == 0);
      tick();
    end
    InValid  = 1'b0;
    auto_ack = 1'b1;
    repeat (100) tick();
    check("drain_model_empty", q.size(), 0);
    check("drain_level", Level, 0);
    check("drain_busy", Busy, 0);

`ifdef FIR_WR_TIMEOUT_EN
    // Unacknowledged request times out, flags Error and retries the same sample.
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    check("to_error_clear", Error, 0);
    auto_ack = 1'b0;
    ReadIn   = 1'b0;
    InValid  = 1'b1;
    InData   = 16'sh8000;
    tick();
    InValid  = 1'b0;
    tick();
    check("to_stop", StopOut, 1);
    for (int i = 1; i < TMO; i++) begin
      tick();
      check("to_send_stop", StopOut, 1);
      check("to_send_error", Error, 0);
    end
    tick();
    check("to_error_set", Error, 1);
    check("to_stop_drop", StopOut, 0);
    check("to_level_kept", Level, 1);
    wait_rise(HOLD + 3, "to_retry");
    check("to_retry_dout", DataOut, 16'sh8000);
    check("to_retry_level", Level, 1);
    check("to_error_sticky", Error, 1);
    ReadIn = 1'b1;
    tick();
    ReadIn = 1'b0;
    repeat (HOLD + 2) tick();
    check("to_end_level", Level, 0);
    check("to_end_error", Error, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
